// File: rtl/router_ingress_ctrl_if.sv
// Source/FIFO-side signal bundle of the router ingress controller.
// slave is the controller's view, master is the view of whatever drives it.
interface router_ingress_ctrl_if;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic [7:0] dout;
   logic [2:0] write_enb;
   logic       busy;
   logic       error;
   logic       pkt_done;
   logic       len_err;

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      output dout, write_enb, busy, error, pkt_done, len_err
   );

   modport master (
      output pkt_valid, data_in, fifo_full,
      input  dout, write_enb, busy, error, pkt_done, len_err
   );
endinterface

// File: rtl/router_ingress_ctrl.sv
// Router 1x3 ingress: header decode, FIFO steering, XOR parity check, busy/timeout.
// Optional payload length check is enabled by the macro ROUTER_LEN_CHECK_EN.
module router_ingress_ctrl #(
   parameter int TIMEOUT_CYCLES = 30
) (
   input  logic                  clock,
   input  logic                  resetn,
   router_ingress_ctrl_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      HOLD  = 3'd2,
      CHECK = 3'd3,
      DROP  = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [1:0]    addr_r, addr_s;
   logic [7:0]    parity_r, parity_s;
   logic [7:0]    rx_parity_r, rx_parity_s;
   logic [7:0]    hold_r, hold_s;
   logic          ret_check_r, ret_check_s;
   logic [TW-1:0] timer_r, timer_s;
   logic [7:0]    dout_r, dout_s;
   logic [2:0]    write_enb_r, write_enb_s;
   logic          busy_r;
   logic          error_r, error_s;
   logic          pkt_done_r, pkt_done_s;
   logic          full_s;
`ifdef ROUTER_LEN_CHECK_EN
   logic [5:0]    count_r, count_s;
   logic [5:0]    len_r, len_s;
   logic          len_err_r, len_err_s;
`endif

   function automatic logic fifo_is_full(input logic [2:0] full, input logic [1:0] a);
      case (a)
         2'd0:    return full[0];
         2'd1:    return full[1];
         2'd2:    return full[2];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] addr_strobe(input logic [1:0] a);
      case (a)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [7:0] parity_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   // In IDLE the destination comes straight from the header byte.
   assign full_s = fifo_is_full(bus.fifo_full, (state_r == IDLE) ? bus.data_in[1:0] : addr_r);

   // Next-state, datapath and output decode.
   always_comb begin
      state_s     = state_r;
      addr_s      = addr_r;
      parity_s    = parity_r;
      rx_parity_s = rx_parity_r;
      hold_s      = hold_r;
      ret_check_s = ret_check_r;
      timer_s     = timer_r;
      dout_s      = dout_r;
      write_enb_s = 3'b000;
      error_s     = error_r;
      pkt_done_s  = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
      count_s     = count_r;
      len_s       = len_r;
      len_err_s   = len_err_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.pkt_valid && (bus.data_in[1:0] == 2'd3)) begin
               state_s = DROP;
            end else if (bus.pkt_valid) begin
               addr_s      = bus.data_in[1:0];
               error_s     = 1'b0;
               ret_check_s = 1'b0;
               timer_s     = '0;
`ifdef ROUTER_LEN_CHECK_EN
               count_s     = 6'd0;
               len_s       = bus.data_in[7:2];
               len_err_s   = 1'b0;
`endif
               if (!full_s) begin
                  dout_s      = bus.data_in;
                  write_enb_s = addr_strobe(bus.data_in[1:0]);
                  parity_s    = bus.data_in;
                  state_s     = LOAD;
               end else begin
                  // Zero accumulator so releasing the held header seeds it.
                  hold_s   = bus.data_in;
                  parity_s = 8'h00;
                  state_s  = HOLD;
               end
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
`ifdef ROUTER_LEN_CHECK_EN
            if (bus.pkt_valid) begin
               count_s = count_r + 6'd1;
            end else begin
               count_s = count_r;
            end
`endif
            if (!full_s) begin
               dout_s      = bus.data_in;
               write_enb_s = addr_strobe(addr_r);
               if (bus.pkt_valid) begin
                  parity_s = parity_step(parity_r, bus.data_in);
               end else begin
                  rx_parity_s = bus.data_in;
                  state_s     = CHECK;
               end
            end else begin
               hold_s      = bus.data_in;
               ret_check_s = !bus.pkt_valid;
               timer_s     = '0;
               state_s     = HOLD;
            end
         end
         HOLD: begin
            if (!full_s) begin
               dout_s      = hold_r;
               write_enb_s = addr_strobe(addr_r);
               timer_s     = '0;
               if (ret_check_r) begin
                  rx_parity_s = hold_r;
                  state_s     = CHECK;
               end else begin
                  parity_s = parity_step(parity_r, hold_r);
                  state_s  = LOAD;
               end
            end else if (timer_r == TIMER_LAST) begin
               timer_s = '0;
               error_s = 1'b1;
               if (ret_check_r) begin
                  pkt_done_s = 1'b1;
                  state_s    = IDLE;
               end else begin
                  state_s = DROP;
               end
            end else begin
               timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         CHECK: begin
            error_s    = (rx_parity_r != parity_r);
            pkt_done_s = 1'b1;
            state_s    = IDLE;
`ifdef ROUTER_LEN_CHECK_EN
            if (count_r != len_r) begin
               len_err_s = 1'b1;
               error_s   = 1'b1;
            end else begin
               len_err_s = 1'b0;
            end
`endif
         end
         DROP: begin
            if (!bus.pkt_valid) begin
               pkt_done_s = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s = DROP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r     <= IDLE;
         addr_r      <= 2'd0;
         parity_r    <= 8'h00;
         rx_parity_r <= 8'h00;
         hold_r      <= 8'h00;
         ret_check_r <= 1'b0;
         timer_r     <= '0;
         dout_r      <= 8'h00;
         write_enb_r <= 3'b000;
         busy_r      <= 1'b0;
         error_r     <= 1'b0;
         pkt_done_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         parity_r    <= parity_s;
         rx_parity_r <= rx_parity_s;
         hold_r      <= hold_s;
         ret_check_r <= ret_check_s;
         timer_r     <= timer_s;
         dout_r      <= dout_s;
         write_enb_r <= write_enb_s;
         busy_r      <= (state_s == HOLD) || (state_s == CHECK);
         error_r     <= error_s;
         pkt_done_r  <= pkt_done_s;
      end
   end

`ifdef ROUTER_LEN_CHECK_EN
   // Payload length counter and its sticky mismatch flag.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count_r   <= 6'd0;
         len_r     <= 6'd0;
         len_err_r <= 1'b0;
      end else begin
         count_r   <= count_s;
         len_r     <= len_s;
         len_err_r <= len_err_s;
      end
   end
   assign bus.len_err = len_err_r;
`else
   assign bus.len_err = 1'b0;
`endif

   assign bus.dout      = dout_r;
   assign bus.write_enb = write_enb_r;
   assign bus.busy      = busy_r;
   assign bus.error     = error_r;
   assign bus.pkt_done  = pkt_done_r;

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Directed testbench for router_ingress_ctrl: framing, parity, back-pressure,
// timeout, drop and reset behaviour (plus length check under ROUTER_LEN_CHECK_EN).
module tb_router_ingress_ctrl;

   logic clock;
   logic resetn;
   router_ingress_ctrl_if bus ();

   router_ingress_ctrl #(.TIMEOUT_CYCLES(30)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks;
   int failures;
   logic [10:0] wlog[$];
   int busy_cnt;
   int done_cnt;
   int multi_cnt;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (bus.write_enb !== 3'b000) wlog.push_back({bus.write_enb, bus.dout});
      if ($countones(bus.write_enb) > 1) multi_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.pkt_done === 1'b1) done_cnt++;
   end

   task automatic send_byte(input logic v, input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      bus.pkt_valid = v;
      bus.data_in   = d;
      for (int k = 0; k < 100 && !ok; k++) begin
         if (bus.busy === 1'b0) ok = 1'b1;
         @(posedge clock);
         #1;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_byte_timeout busy stuck, byte=%0h", d);
      end
   endtask

   task automatic idle(input int n);
      bus.pkt_valid = 1'b0;
      bus.data_in   = 8'h00;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset();
      resetn        = 1'b0;
      bus.pkt_valid = 1'b0;
      bus.data_in   = 8'h00;
      bus.fifo_full = 3'b000;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({bus.dout, bus.write_enb, bus.busy, bus.error, bus.pkt_done, bus.len_err} !== 14'd0) begin
         failures++;
         $display("FAIL reset_values got=%0h exp=0",
                  {bus.dout, bus.write_enb, bus.busy, bus.error, bus.pkt_done, bus.len_err});
      end
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_good_addr0();
      logic [10:0] exp[5];
      int base, b0, d0;
      exp = '{{3'b001, 8'h0C}, {3'b001, 8'h11}, {3'b001, 8'h22}, {3'b001, 8'h33}, {3'b001, 8'h0C}};
      base = wlog.size(); b0 = busy_cnt; d0 = done_cnt;
      send_byte(1'b1, 8'h0C); send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22);
      send_byte(1'b1, 8'h33); send_byte(1'b0, 8'h0C);
      idle(4);
      checks++;
      if (wlog.size() - base !== 5) begin
         failures++;
         $display("FAIL good0_count got=%0d exp=5", wlog.size() - base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[base+i] !== exp[i]) begin
               failures++;
               $display("FAIL good0_write%0d got=%0h exp=%0h", i, wlog[base+i], exp[i]);
            end
         end
      end
      checks++;
      if (bus.error !== 1'b0) begin failures++; $display("FAIL good0_error got=%0b exp=0", bus.error); end
      checks++;
      if (done_cnt - d0 !== 1) begin failures++; $display("FAIL good0_done got=%0d exp=1", done_cnt - d0); end
      checks++;
      if (busy_cnt - b0 !== 1) begin failures++; $display("FAIL good0_busy got=%0d exp=1", busy_cnt - b0); end
   endtask

   task automatic test_bad_parity();
      logic [10:0] exp[5];
      int base;
      exp = '{{3'b100, 8'h0E}, {3'b100, 8'h11}, {3'b100, 8'h22}, {3'b100, 8'h33}, {3'b100, 8'hFF}};
      base = wlog.size();
      send_byte(1'b1, 8'h0E); send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22);
      send_byte(1'b1, 8'h33); send_byte(1'b0, 8'hFF);
      idle(3);
      checks++;
      if (wlog.size() - base !== 5) begin
         failures++;
         $display("FAIL bad_count got=%0d exp=5", wlog.size() - base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[base+i] !== exp[i]) begin
               failures++;
               $display("FAIL bad_write%0d got=%0h exp=%0h", i, wlog[base+i], exp[i]);
            end
         end
      end
      checks++;
      if (bus.error !== 1'b1) begin failures++; $display("FAIL bad_error got=%0b exp=1", bus.error); end
      idle(6);
      checks++;
      if (bus.error !== 1'b1) begin failures++; $display("FAIL bad_error_sticky got=%0b exp=1", bus.error); end
   endtask

   task automatic test_backpressure();
      logic [10:0] exp[5];
      int base, b0;
      exp = '{{3'b010, 8'h0D}, {3'b010, 8'h11}, {3'b010, 8'h22}, {3'b010, 8'h33}, {3'b010, 8'h0D}};
      base = wlog.size(); b0 = busy_cnt;
      send_byte(1'b1, 8'h0D);
      checks++;
      if (bus.error !== 1'b0) begin failures++; $display("FAIL bp_error_clear got=%0b exp=0", bus.error); end
      send_byte(1'b1, 8'h11);
      bus.fifo_full = 3'b010;
      send_byte(1'b1, 8'h22);
      repeat (4) @(posedge clock);
      #1;
      bus.fifo_full = 3'b000;
      send_byte(1'b1, 8'h33); send_byte(1'b0, 8'h0D);
      idle(4);
      checks++;
      if (wlog.size() - base !== 5) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=5", wlog.size() - base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[base+i] !== exp[i]) begin
               failures++;
               $display("FAIL bp_write%0d got=%0h exp=%0h", i, wlog[base+i], exp[i]);
            end
         end
      end
      checks++;
      if (busy_cnt - b0 !== 6) begin failures++; $display("FAIL bp_busy got=%0d exp=6", busy_cnt - b0); end
      checks++;
      if (bus.error !== 1'b0) begin failures++; $display("FAIL bp_error got=%0b exp=0", bus.error); end
   endtask

   task automatic test_timeout();
      int base, b0, d0;
      base = wlog.size(); b0 = busy_cnt; d0 = done_cnt;
      send_byte(1'b1, 8'h0C); send_byte(1'b1, 8'h11);
      bus.fifo_full = 3'b001;
      send_byte(1'b1, 8'h22);
      send_byte(1'b1, 8'h33);
      send_byte(1'b0, 8'h0C);
      idle(3);
      bus.fifo_full = 3'b000;
      checks++;
      if (wlog.size() - base !== 2) begin
         failures++;
         $display("FAIL to_count got=%0d exp=2", wlog.size() - base);
      end else begin
         checks++;
         if (wlog[base+1] !== {3'b001, 8'h11}) begin
            failures++;
            $display("FAIL to_write1 got=%0h exp=%0h", wlog[base+1], {3'b001, 8'h11});
         end
      end
      checks++;
      if (busy_cnt - b0 !== 30) begin failures++; $display("FAIL to_busy got=%0d exp=30", busy_cnt - b0); end
      checks++;
      if (bus.error !== 1'b1) begin failures++; $display("FAIL to_error got=%0b exp=1", bus.error); end
      checks++;
      if (done_cnt - d0 !== 1) begin failures++; $display("FAIL to_done got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_drop_addr3();
      int base, d0;
      base = wlog.size(); d0 = done_cnt;
      send_byte(1'b1, 8'h07); send_byte(1'b1, 8'h55); send_byte(1'b0, 8'h52);
      idle(3);
      checks++;
      if (wlog.size() - base !== 0) begin failures++; $display("FAIL drop_writes got=%0d exp=0", wlog.size() - base); end
      checks++;
      if (done_cnt - d0 !== 1) begin failures++; $display("FAIL drop_done got=%0d exp=1", done_cnt - d0); end
      checks++;
      if (bus.error !== 1'b1) begin failures++; $display("FAIL drop_error_kept got=%0b exp=1", bus.error); end
   endtask

   task automatic test_reset_mid_packet();
      logic [10:0] exp[5];
      int base;
      exp = '{{3'b100, 8'h0E}, {3'b100, 8'h11}, {3'b100, 8'h22}, {3'b100, 8'h33}, {3'b100, 8'h0E}};
      send_byte(1'b1, 8'h0E); send_byte(1'b1, 8'h11);
      #1;
      resetn = 1'b0;
      #1;
      checks++;
      if ({bus.dout, bus.write_enb, bus.busy, bus.error, bus.pkt_done} !== 13'd0) begin
         failures++;
         $display("FAIL midreset_values got=%0h exp=0", {bus.dout, bus.write_enb, bus.busy, bus.error, bus.pkt_done});
      end
      base = wlog.size();
      bus.pkt_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (wlog.size() - base !== 0) begin failures++; $display("FAIL midreset_nowrite got=%0d exp=0", wlog.size() - base); end
      base = wlog.size();
      send_byte(1'b1, 8'h0E); send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22);
      send_byte(1'b1, 8'h33); send_byte(1'b0, 8'h0E);
      idle(4);
      checks++;
      if (wlog.size() - base !== 5) begin
         failures++;
         $display("FAIL postreset_count got=%0d exp=5", wlog.size() - base);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[base+i] !== exp[i]) begin
               failures++;
               $display("FAIL postreset_write%0d got=%0h exp=%0h", i, wlog[base+i], exp[i]);
            end
         end
      end
      checks++;
      if (bus.error !== 1'b0) begin failures++; $display("FAIL postreset_error got=%0b exp=0", bus.error); end
   endtask

`ifdef ROUTER_LEN_CHECK_EN
   task automatic test_len_check();
      send_byte(1'b1, 8'h0D); send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22);
      send_byte(1'b0, 8'h3E);
      idle(3);
      checks++;
      if (bus.len_err !== 1'b1) begin failures++; $display("FAIL len_err got=%0b exp=1", bus.len_err); end
      checks++;
      if (bus.error !== 1'b1) begin failures++; $display("FAIL len_error got=%0b exp=1", bus.error); end
   endtask
`endif

   task automatic test_zero_length();
      int base;
      base = wlog.size();
      send_byte(1'b1, 8'h01); send_byte(1'b0, 8'h01);
      idle(3);
      checks++;
      if (wlog.size() - base !== 2) begin
         failures++;
         $display("FAIL zlen_count got=%0d exp=2", wlog.size() - base);
      end else begin
         checks++;
         if (wlog[base+1] !== {3'b010, 8'h01}) begin
            failures++;
            $display("FAIL zlen_parity_write got=%0h exp=%0h", wlog[base+1], {3'b010, 8'h01});
         end
      end
      checks++;
      if ({bus.error, bus.len_err} !== 2'b00) begin
         failures++;
         $display("FAIL zlen_flags got=%0b exp=00", {bus.error, bus.len_err});
      end
      checks++;
      if (multi_cnt !== 0) begin failures++; $display("FAIL onehot got=%0d exp=0", multi_cnt); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_good_addr0();
      test_bad_parity();
      test_backpressure();
      test_timeout();
      test_drop_addr3();
      test_reset_mid_packet();
`ifdef ROUTER_LEN_CHECK_EN
      test_len_check();
`endif
      test_zero_length();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
